calc_entry_ctrl: RTL

//  Consumer of the keypad interface's key-event bus (btn_press, is_number/is_op/is_eq, num_val, op_val).

---
 rtl/calc_entry_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/calc_entry_ctrl.sv
// Keypad-driven BCD calculator entry controller: operand/op entry, digit-serial add/sub.
// Ports: clk, reset(async low), key bus in; disp_bcd/disp_neg/overflow/result_valid/busy out.
module calc_entry_ctrl #(
  parameter int NDIG = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn_press,
  input  logic            is_number,
  input  logic            is_op,
  input  logic            is_eq,
  input  logic [3:0]      num_val,
  input  logic [1:0]      op_val,
  output logic [4*NDIG-1:0] disp_bcd,
  output logic            disp_neg,
  output logic            overflow,
  output logic            result_valid,
  output logic            busy
);

  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] FULL = CW'(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [2:0] {
    S_A, S_OP, S_B, S_CALC, S_RES
  } state_t;

  state_t state, state_d;

  logic          btn_q;
  logic [W-1:0]  a, b, res;
  logic [CW-1:0] cnt;
  logic [1:0]    op;
  logic          neg_r, ovf_r, carry, calc_q;

  logic ev, dig_ev, op_ev, eq_ev, last, sub;
  logic [3:0] xd, yd, yd_eff, sum_d;
  logic [4:0] sum, sub10;
  logic       sum_c;

  logic [W-1:0] disp_d;
  logic neg_d, ovf_d, rv_d, busy_d;

  // One event per press: rising edge of btn_press.
  assign ev     = btn_press & ~btn_q;
  assign dig_ev = ev & is_number & ~is_op & ~is_eq
                  & (num_val <= 4'd9);
  assign op_ev  = ev & is_op & ~is_number & ~is_eq
                  & ((op_val == 2'd1) | (op_val == 2'd2));
  assign eq_ev  = ev & is_eq & ~is_number & ~is_op;
  assign last   = (cnt == LAST);
  assign sub    = (op == 2'd2);

  // Digit slice; subtraction adds the nines complement
  // of the smaller operand with an initial carry of 1.
  always_comb begin
    xd = '0;
    yd = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt == CW'(i)) begin
        xd = neg_r ? b[i*4 +: 4] : a[i*4 +: 4];
        yd = neg_r ? a[i*4 +: 4] : b[i*4 +: 4];
      end
    end
    yd_eff = sub ? (4'd9 - yd) : yd;
    sum    = {1'b0, xd} + {1'b0, yd_eff} + {4'b0, carry};
    sub10  = sum - 5'd10;
    sum_c  = (sum > 5'd9);
    sum_d  = sum_c ? sub10[3:0] : sum[3:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_A;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_A:    if (op_ev) state_d = S_OP;
      S_OP:   if (dig_ev) state_d = S_B;
      S_B:    if (eq_ev) state_d = S_CALC;
      S_CALC: if (last) state_d = S_RES;
      S_RES: begin
        if (dig_ev)
          state_d = S_A;
        else if (op_ev && !neg_r && !ovf_r)
          state_d = S_OP;
      end
      default: state_d = S_A;
    endcase
  end

  // Outputs are a registered view of the current state,
  // so result_valid lands on the first S_RES cycle.
  always_comb begin
    disp_d = '0;
    neg_d  = 1'b0;
    ovf_d  = 1'b0;
    rv_d   = 1'b0;
    busy_d = 1'b0;
    unique case (state)
      S_A, S_OP: disp_d = a;
      S_B:       disp_d = b;
      S_CALC: begin
        disp_d = b;
        busy_d = 1'b1;
      end
      S_RES: begin
        disp_d = res;
        neg_d  = neg_r;
        ovf_d  = ovf_r;
        rv_d   = calc_q;
      end
      default: disp_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q        <= 1'b0;
      a            <= '0;
      b            <= '0;
      res          <= '0;
      cnt          <= '0;
      op           <= '0;
      neg_r        <= 1'b0;
      ovf_r        <= 1'b0;
      carry        <= 1'b0;
      calc_q       <= 1'b0;
      disp_bcd     <= '0;
      disp_neg     <= 1'b0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      btn_q        <= btn_press;
      calc_q       <= (state == S_CALC);
      disp_bcd     <= disp_d;
      disp_neg     <= neg_d;
      overflow     <= ovf_d;
      result_valid <= rv_d;
      busy         <= busy_d;
      case (state)
        S_A: begin
          if (dig_ev && cnt < FULL) begin
            a   <= {a[W-5:0], num_val};
            cnt <= cnt + 1'b1;
          end
          if (op_ev) op <= op_val;
        end
        S_OP: begin
          if (dig_ev) begin
            b   <= {{(W-4){1'b0}}, num_val};
            cnt <= CW'(1);
          end
          if (op_ev) op <= op_val;
        end
        S_B: begin
          if (dig_ev && cnt < FULL) begin
            b   <= {b[W-5:0], num_val};
            cnt <= cnt + 1'b1;
          end
          if (eq_ev) begin
            cnt   <= '0;
            res   <= '0;
            ovf_r <= 1'b0;
            neg_r <= sub && (a < b);
            carry <= sub;
          end
        end
        S_CALC: begin
          for (int i = 0; i < NDIG; i++)
            if (cnt == CW'(i)) res[i*4 +: 4] <= sum_d;
          carry <= sum_c;
          cnt   <= cnt + 1'b1;
          if (last) begin
            cnt   <= '0;
            ovf_r <= ~sub & sum_c;
          end
        end
        S_RES: begin
          if (dig_ev) begin
            a     <= {{(W-4){1'b0}}, num_val};
            b     <= '0;
            res   <= '0;
            op    <= '0;
            neg_r <= 1'b0;
            ovf_r <= 1'b0;
            cnt   <= CW'(1);
          end else if (op_ev && !neg_r && !ovf_r) begin
            a   <= res;
            b   <= '0;
            cnt <= FULL;
            op  <= op_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
